// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle MIPS multiply/divide unit with HI/LO registers.
// Ports: clk, reset (sync, active-high), start/op/rs_data/rt_data request,
//        busy (operation in flight), hi/lo (architectural registers).
// Optional feature: define MDU_MADD_EN to enable MADD (op 110) / MSUB (op 111);
// when undefined those ops are no-ops.
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MDU_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MSUB  = 3'b111;
`endif

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        launch;

    // Result datapath works only from latched operands, so inputs are
    // free to change once the request has been accepted.
    logic [63:0] mul_s;
    logic [63:0] mul_u;
    logic        div_signed;
    logic [31:0] dvd, dvs, dvs_nz;
    logic [31:0] q_u, r_u;
    logic [31:0] q_res, r_res;
`ifdef MDU_MADD_EN
    logic [63:0] acc;
`endif

    always_comb begin
        mul_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        mul_u = {32'd0, a_q} * {32'd0, b_q};

        // Signed divide is done on magnitudes, then the signs restored:
        // quotient negative when operand signs differ, remainder follows
        // the dividend.
        div_signed = (op_q == OP_DIV);
        dvd = (div_signed && a_q[31]) ? (~a_q + 32'd1) : a_q;
        dvs = (div_signed && b_q[31]) ? (~b_q + 32'd1) : b_q;
        dvs_nz = (dvs == 32'd0) ? 32'd1 : dvs;
        q_u = dvd / dvs_nz;
        r_u = dvd % dvs_nz;
        q_res = (div_signed && (a_q[31] ^ b_q[31])) ? (~q_u + 32'd1) : q_u;
        r_res = (div_signed && a_q[31]) ? (~r_u + 32'd1) : r_u;
`ifdef MDU_MADD_EN
        acc = {hi_q, lo_q};
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        launch  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    unique case (op)
                        OP_MTHI: hi_d = rs_data;
                        OP_MTLO: lo_d = rs_data;
                        OP_DIV, OP_DIVU: begin
                            launch = 1'b1;
                            cnt_d  = DIV_N;
                        end
`ifdef MDU_MADD_EN
                        OP_MADD, OP_MSUB,
`endif
                        OP_MULT, OP_MULTU: begin
                            launch = 1'b1;
                            cnt_d  = MULT_N;
                        end
                        default: begin
                        end
                    endcase
                    if (launch) begin
                        state_d = BUSY;
                        op_d    = op;
                        a_d     = rs_data;
                        b_d     = rt_data;
                    end
                end
            end
            BUSY: begin
                if (cnt_q <= 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    unique case (op_q)
                        OP_MULT:  {hi_d, lo_d} = mul_s;
                        OP_MULTU: {hi_d, lo_d} = mul_u;
                        OP_DIV, OP_DIVU: begin
                            // Zero divisor leaves HI/LO untouched.
                            if (b_q != 32'd0) begin
                                hi_d = r_res;
                                lo_d = q_res;
                            end
                        end
`ifdef MDU_MADD_EN
                        OP_MADD:  {hi_d, lo_d} = acc + mul_s;
                        OP_MSUB:  {hi_d, lo_d} = acc - mul_s;
`endif
                        default: begin
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == BUSY);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit.
// Drives directed vectors and checks busy length and HI/LO results.
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int compared   = 0;
    int mismatched = 0;
    int ncyc;

    mul_div_unit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge, then scramble the operands.
    task automatic issue(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        tick();
        start   = 1'b0;
        rs_data = 32'hA5A5_5A5A;
        rt_data = 32'h0F0F_F0F0;
    endtask

    // Count busy cycles; bounded so a stuck busy cannot hang the run.
    task automatic wait_done(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b1;
        op      = 3'b100;
        rs_data = 32'hDEAD_BEEF;
        rt_data = 32'h0;
        tick();
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        // MULT -2 * 3
        issue(3'b000, 32'hFFFF_FFFE, 32'd3);
        wait_done(ncyc);
        chk("mult_cyc", ncyc, 32'd5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        // MULTU 0xFFFFFFFE * 3
        issue(3'b001, 32'hFFFF_FFFE, 32'd3);
        wait_done(ncyc);
        chk("multu_cyc", ncyc, 32'd5);
        chk("multu_hi", hi, 32'h0000_0002);
        chk("multu_lo", lo, 32'hFFFF_FFFA);

        // DIV -7 / 2
        issue(3'b010, 32'hFFFF_FFF9, 32'd2);
        wait_done(ncyc);
        chk("div_cyc", ncyc, 32'd10);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        // DIVU 7 / 0: HI/LO unchanged
        issue(3'b011, 32'd7, 32'd0);
        wait_done(ncyc);
        chk("divz_cyc", ncyc, 32'd10);
        chk("divz_lo", lo, 32'hFFFF_FFFD);
        chk("divz_hi", hi, 32'hFFFF_FFFF);

        // DIV 7 / -2
        issue(3'b010, 32'd7, 32'hFFFF_FFFE);
        wait_done(ncyc);
        chk("divn_lo", lo, 32'hFFFF_FFFD);
        chk("divn_hi", hi, 32'h0000_0001);

        // DIV overflow case
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(ncyc);
        chk("divov_lo", lo, 32'h8000_0000);
        chk("divov_hi", hi, 32'h0000_0000);

        // DIVU large / 16
        issue(3'b011, 32'hFFFF_FFFF, 32'h10);
        wait_done(ncyc);
        chk("divu_lo", lo, 32'h0FFF_FFFF);
        chk("divu_hi", hi, 32'h0000_000F);

        // MTLO, MTHI
        issue(3'b101, 32'h1234, 32'd0);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        chk("mtlo_lo", lo, 32'h1234);
        chk("mtlo_hi", hi, 32'h0000_000F);
        issue(3'b100, 32'hCAFE, 32'd0);
        chk("mthi_hi", hi, 32'hCAFE);
        chk("mthi_lo", lo, 32'h1234);

        // MULT 5*6, second MULT held during busy must be ignored
        issue(3'b000, 32'd5, 32'd6);
        start   = 1'b1;
        op      = 3'b000;
        rs_data = 32'd7;
        rt_data = 32'd7;
        wait_done(ncyc);
        start = 1'b0;
        chk("ign_cyc", ncyc, 32'd5);
        chk("ign_lo", lo, 32'd30);
        chk("ign_hi", hi, 32'd0);
        tick();
        chk("ign_nobusy", {31'd0, busy}, 32'd0);
        chk("ign_lo2", lo, 32'd30);

        // DIV aborted by reset in busy cycle 4
        issue(3'b010, 32'd100, 32'd3);
        tick();
        tick();
        tick();
        chk("abort_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        issue(3'b000, 32'd3, 32'd4);
        wait_done(ncyc);
        chk("post_cyc", ncyc, 32'd5);
        chk("post_lo", lo, 32'd12);
        chk("post_hi", hi, 32'd0);

`ifdef MDU_MADD_EN
        issue(3'b100, 32'd0, 32'd0);
        issue(3'b101, 32'hFFFF_FFFF, 32'd0);
        issue(3'b110, 32'd1, 32'd1);
        wait_done(ncyc);
        chk("madd_cyc", ncyc, 32'd5);
        chk("madd_hi", hi, 32'd1);
        chk("madd_lo", lo, 32'd0);
        issue(3'b111, 32'd1, 32'd1);
        wait_done(ncyc);
        chk("msub_cyc", ncyc, 32'd5);
        chk("msub_hi", hi, 32'd0);
        chk("msub_lo", lo, 32'hFFFF_FFFF);
`else
        issue(3'b100, 32'hAAAA, 32'd0);
        issue(3'b101, 32'h5555, 32'd0);
        issue(3'b110, 32'd1, 32'd1);
        chk("madd_busy", {31'd0, busy}, 32'd0);
        chk("madd_hi", hi, 32'hAAAA);
        chk("madd_lo", lo, 32'h5555);
        issue(3'b111, 32'd9, 32'd9);
        chk("msub_busy", {31'd0, busy}, 32'd0);
        chk("msub_hi", hi, 32'hAAAA);
        chk("msub_lo", lo, 32'h5555);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
